// File: rtl/puf_ctrl_pkg.sv
// puf_ctrl_pkg: shared state encoding, parameter register map and status bit positions
package puf_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, PARAM, RD, COMPUTE, WR, FINISH} ctrlState;
   localparam logic [7:0] PARAM_OPA = 8'd0;
   localparam logic [7:0] PARAM_OPB = 8'd1;
   localparam logic [7:0] PARAM_BATCH = 8'd2;
   localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
   localparam int LED_BUSY = 0;
   localparam int LED_TIMEOUT = 1;
   localparam int LED_DONE = 2;
endpackage

// File: rtl/puf_watchdog.sv
// puf_watchdog: counts cycles from start; expired is high in the cycle the count reaches TIMEOUT_CYCLES
module puf_watchdog #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic done,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] count;
   logic armed;
   assign expired = armed && count == CW'(TIMEOUT_CYCLES);
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         count <= '0;
         armed <= 1'b0;
      end else if (start) begin
         count <= CW'(1);
         armed <= 1'b1;
      end else if (armed && (done || expired))
         armed <= 1'b0;
      else if (armed)
         count <= count + 1'b1;
endmodule

// File: rtl/puf_batch_controller.sv
// puf_batch_controller: reads operands and batch size, streams challenges to the PUF array and stores each response
module puf_batch_controller
   import puf_ctrl_pkg::*;
#(
   parameter int INMEM_ADDRESS_WIDTH = 17,
   parameter int OUTMEM_ADDRESS_WIDTH = 13,
   parameter int CHAL_BYTES = 16,
   parameter int RESP_BYTES = 2,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int BATCH_WIDTH = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic userRunValue,
   output logic userRunClear,
   output logic register32CmdReq,
   input  logic register32CmdAck,
   output logic [7:0] register32Address,
   output logic register32WriteEn,
   output logic [31:0] register32WriteData,
   input  logic register32ReadDataValid,
   input  logic [31:0] register32ReadData,
   output logic inputMemoryReadReq,
   input  logic inputMemoryReadAck,
   output logic [INMEM_ADDRESS_WIDTH-1:0] inputMemoryReadAdd,
   input  logic inputMemoryReadDataValid,
   input  logic [7:0] inputMemoryReadData,
   output logic outputMemoryWriteReq,
   input  logic outputMemoryWriteAck,
   output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
   output logic [7:0] outputMemoryWriteData,
   output logic outputMemoryWriteByteMask,
   output logic puf_trigger,
   output logic [8*CHAL_BYTES-1:0] puf_challenge,
   output logic [15:0] puf_opA,
   output logic [15:0] puf_opB,
   input  logic puf_done,
   input  logic [8*RESP_BYTES-1:0] puf_response,
   output logic [7:0] LED
);
   localparam int BIW = $clog2(CHAL_BYTES + 1);
   localparam int RIW = $clog2(RESP_BYTES + 1);
   localparam int CW = 8 * CHAL_BYTES;
   localparam int RW = 8 * RESP_BYTES;
   ctrlState state, nextState;
   logic [BIW-1:0] byteIdx;
   logic [RIW-1:0] respIdx;
   logic [1:0] validCnt;
   logic [BATCH_WIDTH-1:0] chalIdx, batchCount;
   logic [RW-1:0] resp;
   logic timeoutSeen, batchDone, expired;
   logic runStart, paramDone, rdDone, cmpDone, wrDone, lastChal;
   logic unusedParamBits;
   assign unusedParamBits = ^register32ReadData;
   assign register32WriteEn = 1'b0;
   assign register32WriteData = '0;
   assign outputMemoryWriteByteMask = 1'b1;
   assign outputMemoryWriteData = resp[7:0];
   assign userRunClear = state == FINISH;
   puf_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) watchdog (
      .clk(clk), .reset(reset), .start(puf_trigger), .done(puf_done), .expired(expired)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= nextState;
   always_comb begin
      runStart = state == IDLE && userRunValue && !userRunClear;
      paramDone = state == PARAM && register32ReadDataValid && validCnt == 2'd2;
      rdDone = state == RD && inputMemoryReadDataValid && byteIdx == BIW'(CHAL_BYTES - 1);
      // a done coinciding with the trigger cannot belong to this challenge
      cmpDone = state == COMPUTE && !puf_trigger && (puf_done || expired);
      wrDone = state == WR && outputMemoryWriteReq && outputMemoryWriteAck && respIdx == RIW'(RESP_BYTES - 1);
      lastChal = BATCH_WIDTH'(chalIdx + 1'b1) == batchCount;
      nextState = state;
      case (state)
         IDLE: if (runStart) nextState = PARAM;
         PARAM: if (paramDone) nextState = register32ReadData[BATCH_WIDTH-1:0] == '0 ? FINISH : RD;
         RD: if (rdDone) nextState = COMPUTE;
         COMPUTE: if (cmpDone) nextState = WR;
         WR: if (wrDone) nextState = lastChal ? FINISH : RD;
         default: nextState = IDLE;
      endcase
      LED = '0;
      LED[LED_BUSY] = state != IDLE;
      LED[LED_TIMEOUT] = timeoutSeen;
      LED[LED_DONE] = batchDone;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         register32CmdReq <= 1'b0;
         register32Address <= '0;
         inputMemoryReadReq <= 1'b0;
         inputMemoryReadAdd <= '0;
         outputMemoryWriteReq <= 1'b0;
         outputMemoryWriteAdd <= '0;
         puf_trigger <= 1'b0;
         puf_challenge <= '0;
         puf_opA <= '0;
         puf_opB <= '0;
         byteIdx <= '0;
         respIdx <= '0;
         validCnt <= '0;
         chalIdx <= '0;
         batchCount <= '0;
         resp <= '0;
         timeoutSeen <= 1'b0;
         batchDone <= 1'b0;
      end else begin
         puf_trigger <= rdDone;
         if (runStart) begin
            register32CmdReq <= 1'b1;
            register32Address <= PARAM_OPA;
            validCnt <= '0;
            timeoutSeen <= 1'b0;
            batchDone <= 1'b0;
            outputMemoryWriteAdd <= '0;
         end
         if (state == PARAM) begin
            if (register32CmdReq && register32CmdAck) begin
               if (register32Address == PARAM_BATCH) register32CmdReq <= 1'b0;
               else register32Address <= register32Address + 1'b1;
            end
            if (register32ReadDataValid) begin
               validCnt <= validCnt + 1'b1;
               if (validCnt == 2'd0) puf_opA <= register32ReadData[15:0];
               else if (validCnt == 2'd1) puf_opB <= register32ReadData[15:0];
               else batchCount <= register32ReadData[BATCH_WIDTH-1:0];
            end
         end
         if (paramDone) begin
            chalIdx <= '0;
            byteIdx <= '0;
            inputMemoryReadAdd <= '0;
            inputMemoryReadReq <= register32ReadData[BATCH_WIDTH-1:0] != '0;
         end
         // input addresses run consecutively across challenges, so a counter replaces chal_idx*CHAL_BYTES+byte_idx
         if (state == RD) begin
            if (inputMemoryReadReq && inputMemoryReadAck) begin
               inputMemoryReadReq <= 1'b0;
               inputMemoryReadAdd <= inputMemoryReadAdd + 1'b1;
            end
            if (inputMemoryReadDataValid) begin
               puf_challenge <= CW'({inputMemoryReadData, puf_challenge} >> 8);
               byteIdx <= byteIdx + 1'b1;
               if (!rdDone) inputMemoryReadReq <= 1'b1;
            end
         end
         if (cmpDone) begin
            resp <= puf_done ? puf_response : {RESP_BYTES{TIMEOUT_FILL}};
            if (!puf_done) timeoutSeen <= 1'b1;
            outputMemoryWriteReq <= 1'b1;
            respIdx <= '0;
         end
         if (state == WR && outputMemoryWriteReq && outputMemoryWriteAck) begin
            outputMemoryWriteAdd <= outputMemoryWriteAdd + 1'b1;
            resp <= RW'(resp >> 8);
            respIdx <= respIdx + 1'b1;
            if (wrDone) begin
               outputMemoryWriteReq <= 1'b0;
               chalIdx <= chalIdx + 1'b1;
               if (!lastChal) begin
                  inputMemoryReadReq <= 1'b1;
                  byteIdx <= '0;
               end
            end
         end
         if (state == FINISH) batchDone <= 1'b1;
      end
endmodule

// File: tb/tb_puf_batch_controller.sv
// tb_puf_batch_controller: randomized memories, register file and PUF around the controller, checked against a batch-level model
module tb_puf_batch_controller;
   localparam int CB = 16;
   localparam int RB = 2;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic userRunValue = 1'b0, userRunClear;
   logic register32CmdReq, register32CmdAck = 1'b0;
   logic [7:0] register32Address;
   logic register32WriteEn;
   logic [31:0] register32WriteData;
   logic register32ReadDataValid = 1'b0;
   logic [31:0] register32ReadData = '0;
   logic inputMemoryReadReq, inputMemoryReadAck = 1'b0;
   logic [16:0] inputMemoryReadAdd;
   logic inputMemoryReadDataValid = 1'b0;
   logic [7:0] inputMemoryReadData = '0;
   logic outputMemoryWriteReq, outputMemoryWriteAck = 1'b0;
   logic [12:0] outputMemoryWriteAdd;
   logic [7:0] outputMemoryWriteData;
   logic outputMemoryWriteByteMask;
   logic puf_trigger;
   logic [127:0] puf_challenge;
   logic [15:0] puf_opA, puf_opB;
   logic puf_done = 1'b0;
   logic [15:0] puf_response = '0;
   logic [7:0] LED;
   int checks = 0, passes = 0, fails = 0;
   logic [7:0] inMem [0:1023];
   logic [7:0] outMem [0:255];
   int outHits [0:255];
   logic [31:0] params [0:2];
   logic [15:0] respTable [0:7];
   int pufDelay [0:7];
   logic [127:0] chalSeen [0:7];
   logic [15:0] opASeen [0:7], opBSeen [0:7];
   int maxD = 0, trigCount = 0, readCount = 0, writeCount = 0, clearCount = 0, stabErr = 0;
   logic [63:0] snap;

   always #5 clk = ~clk;

   puf_batch_controller #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .userRunValue(userRunValue), .userRunClear(userRunClear),
      .register32CmdReq(register32CmdReq), .register32CmdAck(register32CmdAck),
      .register32Address(register32Address), .register32WriteEn(register32WriteEn),
      .register32WriteData(register32WriteData), .register32ReadDataValid(register32ReadDataValid),
      .register32ReadData(register32ReadData), .inputMemoryReadReq(inputMemoryReadReq),
      .inputMemoryReadAck(inputMemoryReadAck), .inputMemoryReadAdd(inputMemoryReadAdd),
      .inputMemoryReadDataValid(inputMemoryReadDataValid), .inputMemoryReadData(inputMemoryReadData),
      .outputMemoryWriteReq(outputMemoryWriteReq), .outputMemoryWriteAck(outputMemoryWriteAck),
      .outputMemoryWriteAdd(outputMemoryWriteAdd), .outputMemoryWriteData(outputMemoryWriteData),
      .outputMemoryWriteByteMask(outputMemoryWriteByteMask), .puf_trigger(puf_trigger),
      .puf_challenge(puf_challenge), .puf_opA(puf_opA), .puf_opB(puf_opB),
      .puf_done(puf_done), .puf_response(puf_response), .LED(LED)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // register file: data valid in the cycle after each accepted read
   initial begin : regResp
      logic hs;
      logic [7:0] a;
      int w;
      w = 0;
      forever begin
         @(posedge clk);
         hs = register32CmdReq && register32CmdAck;
         a = register32Address;
         @(negedge clk);
         register32ReadDataValid = hs && !reset;
         register32ReadData = (hs && a < 8'd3) ? params[a[1:0]] : 32'h0;
         if (hs || reset) begin
            register32CmdAck = 1'b0;
            w = $urandom_range(0, maxD);
         end
         if (register32CmdReq && !register32CmdAck) begin
            if (w == 0) register32CmdAck = 1'b1;
            else w--;
         end
      end
   end

   initial begin : inResp
      logic hs;
      logic [16:0] a;
      int w;
      w = 0;
      forever begin
         @(posedge clk);
         hs = inputMemoryReadReq && inputMemoryReadAck;
         a = inputMemoryReadAdd;
         if (hs) readCount++;
         @(negedge clk);
         inputMemoryReadDataValid = hs && !reset;
         inputMemoryReadData = hs ? inMem[a[9:0]] : 8'h0;
         if (hs || reset) begin
            inputMemoryReadAck = 1'b0;
            w = $urandom_range(0, maxD);
         end
         if (inputMemoryReadReq && !inputMemoryReadAck) begin
            if (w == 0) inputMemoryReadAck = 1'b1;
            else w--;
         end
      end
   end

   initial begin : outResp
      logic hs;
      int w;
      w = 0;
      forever begin
         @(posedge clk);
         hs = outputMemoryWriteReq && outputMemoryWriteAck;
         if (hs) begin
            writeCount++;
            outMem[outputMemoryWriteAdd[7:0]] = outputMemoryWriteData;
            outHits[outputMemoryWriteAdd[7:0]]++;
         end
         @(negedge clk);
         if (hs || reset) begin
            outputMemoryWriteAck = 1'b0;
            w = $urandom_range(0, maxD);
         end
         if (outputMemoryWriteReq && !outputMemoryWriteAck) begin
            if (w == 0) outputMemoryWriteAck = 1'b1;
            else w--;
         end
      end
   end

   // run register: cleared by the pulse, seen low from the following cycle
   initial forever begin
      @(posedge clk);
      if (userRunClear) begin
         clearCount++;
         @(negedge clk);
         userRunValue = 1'b0;
      end
   end

   // PUF: response pufDelay[i] cycles after the trigger of challenge i, one-cycle done
   initial begin : pufModel
      int cnt, cur;
      bit armed;
      armed = 0;
      cnt = 0;
      cur = 0;
      forever begin
         @(negedge clk);
         puf_done = 1'b0;
         if (reset) armed = 0;
         else if (puf_trigger) begin
            if (trigCount < 8) begin
               chalSeen[trigCount] = puf_challenge;
               opASeen[trigCount] = puf_opA;
               opBSeen[trigCount] = puf_opB;
            end
            cur = trigCount < 8 ? trigCount : 7;
            trigCount++;
            armed = 1;
            cnt = 0;
         end else if (armed) begin
            cnt++;
            if (cnt == pufDelay[cur]) begin
               puf_done = 1'b1;
               puf_response = respTable[cur];
               armed = 0;
            end
         end
      end
   end

   initial begin : stability
      logic iw, ow, cw;
      logic [16:0] ia;
      logic [12:0] oa;
      logic [7:0] od, ca;
      iw = 0; ow = 0; cw = 0;
      ia = '0; oa = '0; od = '0; ca = '0;
      forever begin
         @(posedge clk);
         if (iw && !(inputMemoryReadReq && inputMemoryReadAdd == ia)) stabErr++;
         if (ow && !(outputMemoryWriteReq && outputMemoryWriteAdd == oa && outputMemoryWriteData == od)) stabErr++;
         if (cw && !(register32CmdReq && register32Address == ca)) stabErr++;
         iw = inputMemoryReadReq && !inputMemoryReadAck && !reset;
         ow = outputMemoryWriteReq && !outputMemoryWriteAck && !reset;
         cw = register32CmdReq && !register32CmdAck && !reset;
         ia = inputMemoryReadAdd;
         oa = outputMemoryWriteAdd;
         od = outputMemoryWriteData;
         ca = register32Address;
      end
   end

   task automatic runBatch(input string name, input int batch);
      logic [127:0] expChal;
      logic [15:0] expResp;
      bit anyTimeout;
      int cyc;
      anyTimeout = 0;
      params[2] = {16'hA5A5, 16'(batch)};
      trigCount = 0; readCount = 0; writeCount = 0; clearCount = 0; stabErr = 0;
      for (int i = 0; i < 256; i++) begin
         outMem[i] = 8'h0;
         outHits[i] = 0;
      end
      @(negedge clk);
      userRunValue = 1'b1;
      cyc = 0;
      while (clearCount == 0 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      check({name, "_clear"}, clearCount, 1);
      check({name, "_reads"}, readCount, batch * CB);
      check({name, "_writes"}, writeCount, batch * RB);
      check({name, "_triggers"}, trigCount, batch);
      check({name, "_stable"}, stabErr, 0);
      for (int i = 0; i < batch && i < 8; i++) begin
         for (int j = 0; j < CB; j++) expChal[8*j +: 8] = inMem[i*CB + j];
         check($sformatf("%s_chal%0d", name, i), chalSeen[i], expChal);
         check($sformatf("%s_opA%0d", name, i), opASeen[i], params[0][15:0]);
         check($sformatf("%s_opB%0d", name, i), opBSeen[i], params[1][15:0]);
         expResp = pufDelay[i] <= TO ? respTable[i] : 16'hFFFF;
         if (pufDelay[i] > TO) anyTimeout = 1;
         for (int k = 0; k < RB; k++) begin
            check($sformatf("%s_out%0d", name, i*RB + k), outMem[i*RB + k], expResp[8*k +: 8]);
            check($sformatf("%s_hits%0d", name, i*RB + k), outHits[i*RB + k], 1);
         end
      end
      check({name, "_led"}, LED, {5'b0, 1'b1, anyTimeout, 1'b0});
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge clk);
      check("rst_cmdreq", register32CmdReq, 0);
      check("rst_inreq", inputMemoryReadReq, 0);
      check("rst_outreq", outputMemoryWriteReq, 0);
      check("rst_trigger", puf_trigger, 0);
      check("rst_clear", userRunClear, 0);
      check("rst_led", LED, 0);
      check("rst_addrs", {register32Address, inputMemoryReadAdd, outputMemoryWriteAdd, outputMemoryWriteData}, 0);
      check("rst_ties", {register32WriteEn, register32WriteData, outputMemoryWriteByteMask}, 1);
      reset = 1'b0;

      params[0] = 32'h0000_1234;
      params[1] = 32'h0000_5678;
      for (int i = 0; i < 1024; i++) inMem[i] = 8'(i);
      respTable[0] = 16'hBEEF;
      pufDelay[0] = 10;
      runBatch("single", 1);
      check("single_chal_const", chalSeen[0], 128'h0F0E0D0C0B0A09080706050403020100);
      check("single_no_addr2", outHits[2], 0);
      check("single_bytes", {outMem[1], outMem[0]}, 16'hBEEF);

      params[0] = $urandom;
      params[1] = $urandom;
      for (int i = 0; i < 8; i++) begin
         respTable[i] = 16'(16 * i);
         pufDelay[i] = $urandom_range(1, 20);
      end
      runBatch("batch3", 3);

      runBatch("empty", 0);

      for (int i = 0; i < 1024; i++) inMem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) respTable[i] = 16'($urandom);
      pufDelay[0] = 1000;
      pufDelay[1] = TO;
      pufDelay[2] = TO + 1;
      runBatch("timeout", 3);

      for (int i = 0; i < 8; i++) pufDelay[i] = $urandom_range(1, 30);
      maxD = 0;
      runBatch("fast", 4);
      for (int i = 0; i < 8; i++) snap[8*i +: 8] = outMem[i];
      maxD = 5;
      runBatch("slow", 4);
      check("slow_vs_fast", {outMem[7], outMem[6], outMem[5], outMem[4], outMem[3], outMem[2], outMem[1], outMem[0]}, snap);

      maxD = 2;
      params[2] = 32'd2;
      @(negedge clk);
      userRunValue = 1'b1;
      cyc = 0;
      while (!outputMemoryWriteReq && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_reached_wr", outputMemoryWriteReq, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_reqs", {register32CmdReq, inputMemoryReadReq, outputMemoryWriteReq, puf_trigger, userRunClear}, 0);
      check("abort_led", LED, 0);
      userRunValue = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      runBatch("after_reset", 2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
